// File: rtl/output_port_pkg.sv
// Shared configuration for the output port: word width and default buffer depth.
`ifndef WORDSIZE
`define WORDSIZE 8
`endif
`ifndef OUT_DEPTH
`define OUT_DEPTH 4
`endif

package output_port_pkg;
  localparam int WORD_W    = `WORDSIZE;
  localparam int DEPTH_DEF = `OUT_DEPTH;
endpackage

// File: rtl/output_port.sv
// CPU-written output FIFO drained by a valid/ready consumer.
//
// state   | meaning
// EMPTY   | no words held; q reads 0 and ready is ignored
// PARTIAL | 0 < count < DEPTH
// FULL    | DEPTH words held; writes are rejected and flagged in ovf
//
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module output_port
  import output_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [WORD_W-1:0]          d,
  input  logic                       ld,
  output logic                       full,
  output logic [WORD_W-1:0]          q,
  output logic                       valid,
  input  logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              push, pop;

  // Flags come straight from the occupancy state so ld/ready never reach them.
  assign full  = (state_q == FULL);
  assign valid = (state_q != EMPTY);
  assign count = count_q;
  assign ovf   = ovf_q;
  assign q     = valid ? mem_q[rd_ptr_q] : '0;

  // A write while full is dropped even when a pop frees a slot on the same edge.
  assign push = ld & ~full;
  assign pop  = valid & ready;

  // Next occupancy, pointers and sticky overflow.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (ld & full);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)          state_d = EMPTY;
    else if (count_d == DEPTH_C) state_d = FULL;
    else                         state_d = PARTIAL;
  end

  // Occupancy FSM and pointer registers; clr drops everything at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Word storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= d;
  end

endmodule

// File: tb/tb_output_port.sv
// Self-checking bench for output_port against a queue-based FIFO model.
module tb_output_port;
  import output_port_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic [WORD_W-1:0] d;
  logic              ld;
  logic              full;
  logic [WORD_W-1:0] q;
  logic              valid;
  logic              ready;
  logic [2:0]        count;
  logic              ovf;

  int n_cmp = 0;
  int n_err = 0;

  logic [WORD_W-1:0] mdl[$];
  logic              mdl_ovf = 1'b0;

  always #5 clk = ~clk;

  output_port #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .clr   (clr),
    .d     (d),
    .ld    (ld),
    .full  (full),
    .q     (q),
    .valid (valid),
    .ready (ready),
    .count (count),
    .ovf   (ovf)
  );

  // Drive one clock of stimulus, advance the model by the FIFO rules, settle 1ns past the edge.
  task automatic cycle(input logic l, input logic [WORD_W-1:0] dv, input logic r);
    bit was_full, was_valid;
    ld = l; d = dv; ready = r;
    @(posedge clk);
    was_full  = (mdl.size() == DEPTH);
    was_valid = (mdl.size() != 0);
    if (l && was_full) mdl_ovf = 1'b1;
    if (was_valid && r) void'(mdl.pop_front());
    if (l && !was_full) mdl.push_back(dv);
    #1;
  endtask

  task automatic apply_clr();
    ld = 1'b0; ready = 1'b0;
    #2 clr = 1'b1;
    #1 clr = 1'b0;
    mdl.delete();
    mdl_ovf = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; ld = 1'b0; ready = 1'b0; d = '0;
    #12;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (full !== 1'b0)  begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (q !== '0)       begin n_err++; $display("FAIL reset_q: got %h want 0", q); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    clr = 1'b0;
    // Overfill to set ovf, then drain down to 2 words held.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    n_cmp++; if (count !== 3'd2 || ovf !== 1'b1) begin n_err++; $display("FAIL reset_pre: got count=%0d ovf=%b want count=2 ovf=1", count, ovf); end
    // Asynchronous clear mid-cycle, observed before any further clock edge.
    ld = 1'b1; d = 8'hEE; ready = 1'b1;
    #2 clr = 1'b1;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL async_clr_count: got %0d want 0", count); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL async_clr_valid: got %b want 0", valid); end
    n_cmp++; if (q !== '0)       begin n_err++; $display("FAIL async_clr_q: got %h want 0", q); end
    n_cmp++; if (ovf !== 1'b0)   begin n_err++; $display("FAIL async_clr_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 3'd0 || valid !== 1'b0) begin n_err++; $display("FAIL clr_hold: got count=%0d valid=%b want 0 0", count, valid); end
    clr = 1'b0; ld = 1'b0; ready = 1'b0;
    mdl.delete(); mdl_ovf = 1'b0;
    cycle(1'b1, 8'h11, 1'b0);
    n_cmp++; if (q !== 8'h11 || valid !== 1'b1 || count !== 3'd1) begin n_err++; $display("FAIL post_clr_push: got q=%h valid=%b count=%0d want 11 1 1", q, valid, count); end
  endtask

  task automatic test_ordering();
    logic [WORD_W-1:0] exp_w;
    apply_clr();
    cycle(1'b1, 8'h01, 1'b0);
    n_cmp++; if (valid !== 1'b1 || q !== 8'h01) begin n_err++; $display("FAIL order_latency: got valid=%b q=%h want 1 01", valid, q); end
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL order_count: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      exp_w = 8'h01 + 8'(i);
      n_cmp++; if (q !== exp_w || valid !== 1'b1) begin n_err++; $display("FAIL order_q%0d: got %h valid=%b want %h", i, q, valid, exp_w); end
      cycle(1'b0, '0, 1'b1);
    end
    n_cmp++; if (valid !== 1'b0 || q !== '0) begin n_err++; $display("FAIL order_empty: got valid=%b q=%h want 0 00", valid, q); end
    // Ready while empty must not disturb anything.
    cycle(1'b0, '0, 1'b1);
    n_cmp++; if (count !== 3'd0 || valid !== 1'b0) begin n_err++; $display("FAIL empty_ready: got count=%0d valid=%b want 0 0", count, valid); end
  endtask

  task automatic test_overflow();
    logic [WORD_W-1:0] exp_w;
    apply_clr();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0);
    n_cmp++; if (full !== 1'b1)  begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d want 4", count); end
    n_cmp++; if (ovf !== 1'b1)   begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    // Write with a same-edge pop while full: rejected, head still advances.
    cycle(1'b1, 8'h77, 1'b1);
    n_cmp++; if (count !== 3'd3 || q !== 8'h32) begin n_err++; $display("FAIL full_ld_pop: got count=%0d q=%h want 3 32", count, q); end
    for (int i = 1; i < 4; i++) begin
      exp_w = 8'h31 + 8'(i);
      n_cmp++; if (q !== exp_w) begin n_err++; $display("FAIL ovf_drain%0d: got %h want %h", i, q, exp_w); end
      cycle(1'b0, '0, 1'b1);
    end
    n_cmp++; if (valid !== 1'b0 || ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got valid=%b ovf=%b want 0 1", valid, ovf); end
  endtask

  task automatic test_simultaneous();
    apply_clr();
    cycle(1'b1, 8'h41, 1'b0);
    cycle(1'b1, 8'h42, 1'b0);
    cycle(1'b1, 8'h43, 1'b1);
    n_cmp++; if (count !== 3'd2 || q !== 8'h42) begin n_err++; $display("FAIL simul: got count=%0d q=%h want 2 42", count, q); end
    cycle(1'b0, '0, 1'b1);
    n_cmp++; if (q !== 8'h43 || count !== 3'd1) begin n_err++; $display("FAIL simul_tail: got q=%h count=%0d want 43 1", q, count); end
  endtask

  task automatic test_stall();
    apply_clr();
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'h6B, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(i == 2, 8'h7C, 1'b0);
      n_cmp++; if (q !== 8'h5A || valid !== 1'b1) begin n_err++; $display("FAIL stall%0d: got q=%h valid=%b want 5a 1", i, q, valid); end
    end
  endtask

  task automatic test_wraparound();
    logic [WORD_W-1:0] sent[$];
    int pushed, popped;
    logic l, r;
    logic [WORD_W-1:0] w;
    apply_clr();
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 10; cyc++) begin
      l = (pushed < 10) && (mdl.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 2) != 0);
      w = WORD_W'($urandom);
      if (mdl.size() > 0 && r) begin
        n_cmp++; if (q !== sent[popped]) begin n_err++; $display("FAIL wrap_word%0d: got %h want %h", popped, q, sent[popped]); end
        popped++;
      end
      if (l) begin sent.push_back(w); pushed++; end
      cycle(l, w, r);
    end
    n_cmp++; if (popped != 10 || valid !== 1'b0) begin n_err++; $display("FAIL wrap_done: got popped=%0d valid=%b want 10 0", popped, valid); end
  endtask

  task automatic test_random();
    logic [WORD_W-1:0] exp_q;
    apply_clr();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, WORD_W'($urandom), $urandom_range(0, 2) == 0);
      exp_q = (mdl.size() > 0) ? mdl[0] : '0;
      n_cmp++; if (count !== 3'(mdl.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, mdl.size()); end
      n_cmp++; if (full !== (mdl.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full@%0d: got %b", i, full); end
      n_cmp++; if (valid !== (mdl.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b", i, valid); end
      n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL rnd_q@%0d: got %h want %h", i, q, exp_q); end
      n_cmp++; if (ovf !== mdl_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, ovf, mdl_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_overflow();
    test_simultaneous();
    test_stall();
    test_wraparound();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_port.md
OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 DEPTH, 4, number of buffered words; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  reset, asynchronous and active-high; SHALL force all state to reset values immediately.
REQ-004 d  input  `WORDSIZE  word from the CPU bus to be written to the port.
REQ-005 ld  input  1  write strobe; d SHALL be sampled on a rising clk edge while ld=1.
REQ-006 full  output  1  SHALL be 1 when DEPTH words are held.
REQ-007 q  output  `WORDSIZE  head word presented to the consumer.
REQ-008 valid  output  1  SHALL be 1 when q holds an unread word.
REQ-009 ready  input  1  consumer accepts q on a rising edge where valid=1 and ready=1.
REQ-010 count  output  clog2(DEPTH+1)  number of words held.
REQ-011 ovf  output  1  sticky flag; write attempted while full.

Function
REQ-012 The block SHALL be a FIFO drained by a valid/ready consumer: push = ld & !full; pop = valid & ready.
REQ-013 Occupancy SHALL be tracked as states EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH); full=1 only in FULL, valid=1 in PARTIAL and FULL.
REQ-014 Transitions: push-only increments count; pop-only decrements count; push and pop on the same edge leave count unchanged.
REQ-015 Latency: a word pushed at edge N into an EMPTY buffer SHALL appear on q with valid=1 after edge N; there is no same-cycle fall-through.
REQ-016 Order SHALL be strict first-in first-out; write and read pointers SHALL wrap modulo DEPTH.
REQ-017 In FULL, ld=1 SHALL be rejected even if a pop occurs on the same edge, and ovf SHALL be set; the stored data SHALL be unchanged.
REQ-018 ovf SHALL stay 1 until clr.
REQ-019 In EMPTY, ready SHALL be ignored and q SHALL read 0.
REQ-020 q SHALL be held stable while valid=1 and ready=0.
REQ-021 count, full and valid SHALL be registered, or derived only from registered state; they SHALL have no combinational path from ld or ready.

Reset
REQ-022 While clr=1: count=0, full=0, valid=0, q=0, ovf=0, both pointers=0; storage contents are don't-care.
REQ-023 clr asserted mid-operation SHALL discard all buffered words, with no partial pop or push completing.
REQ-024 After clr deasserts, the first rising edge with ld=1 SHALL push normally.

Structure
REQ-025 WORDSIZE SHALL come from the shared defines.v; the default DEPTH SHALL be added there as OUT_DEPTH.
REQ-026 The state encoding (EMPTY, PARTIAL, FULL) SHALL be local to the module; it is not shared.
REQ-027 The block SHALL be flat with no sub-module; storage SHALL be an internal DEPTH x `WORDSIZE register array.
REQ-028 The implementation SHALL contain no latches and no combinational loops.

Verification
REQ-029 Reset: assert clr asynchronously mid-cycle with 2 words held -> count, valid, q and ovf read 0 immediately; the next push of 0x11 appears on q.
REQ-030 Ordering: push 0x01, 0x02, 0x03 with ready=0, then hold ready=1 -> q reads 0x01, 0x02, 0x03 on successive cycles, then valid=0.
REQ-031 Full/overflow: push 5 words with DEPTH=4 and ready=0 -> full=1, count=4, ovf=1, and the 5th word is never output.
REQ-032 Simultaneous: at count=2, ld=1 and ready=1 on the same edge -> count stays 2, the head advances and the new word is queued last.
REQ-033 Wrap-around: run 10 push/pop pairs with random stalls -> every word is output in order and pointers wrap with no loss.
REQ-034 Stall: valid=1 with ready=0 for 5 cycles -> q is unchanged throughout.
